// File: rtl/guesser_pkg.sv
// Shared types and helpers for the binary-search guesser.
// Holds the FSM state encoding, datapath widths and the midpoint helper.
package guesser_pkg;

    localparam int GUESS_W = 8;
    localparam int CNT_W   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_EVAL,
        S_DONE,
        S_ERROR
    } state_e;

    function automatic logic [GUESS_W-1:0] mid_guess(
        input logic [GUESS_W-1:0] lo,
        input logic [GUESS_W-1:0] hi
    );
        logic [GUESS_W:0] sum;
        sum = {1'b0, lo} + {1'b0, hi};
        return GUESS_W'(sum >> 1);
    endfunction

endpackage

// File: rtl/guess_eval.sv
// Combinational judge of one responder answer.
// Produces the narrowed search window and a done/error verdict.
module guess_eval
    import guesser_pkg::*;
(
    input  logic               over_i,
    input  logic               under_i,
    input  logic               equal_i,
    input  logic [GUESS_W-1:0] guess_i,
    input  logic [GUESS_W-1:0] lo_i,
    input  logic [GUESS_W-1:0] hi_i,
    output logic [GUESS_W-1:0] lo_o,
    output logic [GUESS_W-1:0] hi_o,
    output logic               done_o,
    output logic               err_o
);

    logic bad;

    // Decode the one-hot answer; anything else, or a window that
    // would step past 0/255 or collapse (lo>hi), is an error.
    always_comb begin
        lo_o   = lo_i;
        hi_o   = hi_i;
        done_o = 1'b0;
        bad    = 1'b0;
        unique case ({over_i, under_i, equal_i})
            3'b001: done_o = 1'b1;
            3'b100: begin
                if (guess_i == '0) bad = 1'b1;
                else               hi_o = guess_i - 1'b1;
            end
            3'b010: begin
                if (guess_i == '1) bad = 1'b1;
                else               lo_o = guess_i + 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (!bad && !done_o && (lo_o > hi_o)) bad = 1'b1;
        err_o = bad;
    end

endmodule

// File: rtl/auto_guesser.sv
// Binary-search guesser driving an external responder.
// Issues a guess, waits RESP_LAT cycles, then narrows on the answer.
module auto_guesser
    import guesser_pkg::*;
#(
    parameter int unsigned RESP_LAT = 2
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               dp_over,
    input  logic               dp_under,
    input  logic               dp_equal,
    output logic               enter,
    output logic [GUESS_W-1:0] guess,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [CNT_W-1:0]   num_guesses
);

    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RESP_LAT - 1);

    state_e             state_q;
    logic [GUESS_W-1:0] lo_q;
    logic [GUESS_W-1:0] hi_q;
    logic [GUESS_W-1:0] guess_q;
    logic [GUESS_W-1:0] guess_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [CNT_W-1:0]   wait_q;
    logic               enter_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic [GUESS_W-1:0] ev_lo;
    logic [GUESS_W-1:0] ev_hi;
    logic               ev_done;
    logic               ev_err;

    guess_eval u_eval (
        .over_i  (dp_over),
        .under_i (dp_under),
        .equal_i (dp_equal),
        .guess_i (guess_q),
        .lo_i    (lo_q),
        .hi_i    (hi_q),
        .lo_o    (ev_lo),
        .hi_o    (ev_hi),
        .done_o  (ev_done),
        .err_o   (ev_err)
    );

    assign guess_d = mid_guess(ev_lo, ev_hi);
    assign cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // Search FSM with registered outputs; enter is high only in DRIVE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            lo_q    <= '0;
            hi_q    <= '1;
            guess_q <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
            enter_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            enter_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        lo_q    <= '0;
                        hi_q    <= '1;
                        guess_q <= mid_guess('0, '1);
                        cnt_q   <= CNT_W'(1);
                        enter_q <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    wait_q  <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_q == LAT_LAST) state_q <= S_EVAL;
                    else                    wait_q  <= wait_q + 1'b1;
                end
                S_EVAL: begin
                    lo_q <= ev_lo;
                    hi_q <= ev_hi;
                    if (ev_err) begin
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= S_ERROR;
                    end else if (ev_done) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        guess_q <= guess_d;
                        cnt_q   <= cnt_d;
                        enter_q <= 1'b1;
                        state_q <= S_DRIVE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign enter       = enter_q;
    assign guess       = guess_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = err_q;
    assign num_guesses = cnt_q;

endmodule

// File: tb/tb_auto_guesser.sv
// Directed bench for auto_guesser with a behavioural responder.
// Expected guess sequences are hand-computed binary-search traces.
module tb_auto_guesser;

    localparam int RESP_LAT = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       dp_over, dp_under, dp_equal;
    logic       enter;
    logic [7:0] guess;
    logic       busy, done, error;
    logic [3:0] num_guesses;

    int total = 0;
    int bad = 0;
    int hidden = 0;
    int mode = 0;
    int cyc = 0;
    int wide = 0;
    logic enter_prev = 1'b0;
    int gq[$];
    int gt[$];
    int exp_q[$];

    auto_guesser #(.RESP_LAT(RESP_LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dp_over     (dp_over),
        .dp_under    (dp_under),
        .dp_equal    (dp_equal),
        .enter       (enter),
        .guess       (guess),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .num_guesses (num_guesses)
    );

    always #5 clk = ~clk;

    // Responder: 0 honest, 1 always answers over, 2 never answers.
    always_comb begin
        dp_over  = 1'b0;
        dp_under = 1'b0;
        dp_equal = 1'b0;
        case (mode)
            0: begin
                dp_over  = (int'(guess) > hidden);
                dp_under = (int'(guess) < hidden);
                dp_equal = (int'(guess) == hidden);
            end
            1: dp_over = 1'b1;
            default: ;
        endcase
    end

    // Record each enter pulse and its cycle stamp.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        enter_prev <= enter;
        if (enter) begin
            gq.push_back(int'(guess));
            gt.push_back(cyc);
        end
        if (enter && enter_prev) wide <= wide + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic play(input int hid, input int md, input bit spam,
                        input bit exp_done, input string tag);
        int n;
        mode = md;
        hidden = hid;
        gq.delete();
        gt.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (n = 0; n < 300; n++) begin
            if (done || error) break;
            start = spam && (n % 2 == 0);
            @(negedge clk);
            start = 1'b0;
        end
        check({tag, "_timeout"}, (n >= 300), 0);
        repeat (6) @(negedge clk);
        check({tag, "_n"}, gq.size(), exp_q.size());
        foreach (exp_q[i])
            check($sformatf("%s_g%0d", tag, i),
                  (i < gq.size()) ? gq[i] : -1, exp_q[i]);
        for (int i = 1; i < gt.size(); i++)
            check({tag, "_gap"}, gt[i] - gt[i-1], RESP_LAT + 2);
        check({tag, "_done"}, done, exp_done);
        check({tag, "_err"}, error, !exp_done);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_num"}, num_guesses, exp_q.size());
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_enter", enter, 0);
        check("rst_guess", guess, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", error, 0);
        check("rst_num", num_guesses, 0);
        reset = 1'b0;

        exp_q = {127, 63, 95, 111, 103, 99, 101, 100};
        play(100, 0, 0, 1, "h100");

        exp_q = {127};
        play(127, 0, 0, 1, "h127");

        exp_q = {127, 63, 31, 15, 7, 3, 1, 0};
        play(0, 0, 0, 1, "h0");

        exp_q = {127, 191, 223, 239, 247, 251, 253, 254, 255};
        play(255, 0, 0, 1, "h255");

        exp_q = {127, 63, 31, 15, 7, 3, 1, 0};
        play(0, 1, 0, 0, "ovr0");
        check("ovr0_guess_hold", guess, 0);

        exp_q = {127};
        play(50, 2, 0, 0, "noflag");

        exp_q = {127, 63, 95, 111, 103, 99, 101, 100};
        play(100, 0, 1, 1, "spam");

        mode = 0;
        hidden = 100;
        gq.delete();
        gt.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (n = 0; n < 300 && gq.size() < 3; n++) @(negedge clk);
        check("mid_timeout", (n >= 300), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_busy", busy, 0);
        check("mid_enter", enter, 0);
        check("mid_num", num_guesses, 0);
        check("mid_guess", guess, 0);
        repeat (12) @(negedge clk);
        check("mid_no_enter", gq.size(), 3);
        check("mid_idle_busy", busy, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("re_enter", enter, 1);
        check("re_guess", guess, 127);
        check("re_num", num_guesses, 1);
        for (n = 0; n < 300 && !(done || error); n++) @(negedge clk);
        check("re_done", done, 1);
        check("re_num_end", num_guesses, 8);

        check("pulse_wide", wide, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
